// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_ctrl
// Purpose  : Owns the single port of the SPRAM-backed instruction memory.
//            After reset, loader bytes are packed into 32-bit little-endian
//            words and written to PROG_WORDS consecutive words starting at
//            BASE_ADDR. The port is then handed to the CPU fetch path and
//            cpu_run is raised.
//
// Parameters
//   ADDR_W      byte-address width of the instruction memory
//   PROG_WORDS  number of 32-bit words loaded at boot (>= 1)
//   BASE_ADDR   first byte address written (4-byte aligned)
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   byte_valid    loader byte present
//   byte_data     loader byte
//   byte_ready    loader byte accepted when byte_valid & byte_ready
//   fetch_req     CPU fetch request (single cycle, may be back-to-back)
//   fetch_addr    CPU fetch byte address
//   fetch_valid   fetch_data valid, one cycle after an accepted fetch_req
//   fetch_data    fetched instruction (memory read data, unmodified)
//   mem_addr      instruction memory byte address
//   mem_wr_en     instruction memory write enable
//   mem_wdata     instruction memory write data
//   mem_rdata     instruction memory read data (registered, 1-cycle latency)
//   cpu_run       program loaded, CPU may execute
//   reload        (IMEM_RELOAD_EN only) restart the load sequence from RUN
//   words_loaded  words written since the last load start
//
// Build option
//   IMEM_RELOAD_EN  when defined, adds the reload input; otherwise RUN is
//                   terminal until rst_n is asserted.
//
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int PROG_WORDS = 4096,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    // boot byte stream
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    // CPU fetch interface
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_valid,
    output logic [31:0]         fetch_data,
    // instruction memory port
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wr_en,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    // status
    output logic                cpu_run,
`ifdef IMEM_RELOAD_EN
    input  logic                reload,
`endif
    output logic [ADDR_W-2:0]   words_loaded
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    localparam longint c_load_end = longint'(BASE_ADDR) + (longint'(4) * longint'(PROG_WORDS));
    localparam longint c_mem_size = longint'(1) << ADDR_W;

    generate
        if (PROG_WORDS < 1) begin : g_bad_prog_words
            $error("imem_boot_ctrl: PROG_WORDS must be at least 1");
        end
        if ((BASE_ADDR % 4) != 0) begin : g_bad_base_align
            $error("imem_boot_ctrl: BASE_ADDR must be 4-byte aligned");
        end
        if (c_load_end > c_mem_size) begin : g_bad_range
            $error("imem_boot_ctrl: BASE_ADDR + 4*PROG_WORDS exceeds 2**ADDR_W");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_base_addr  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_word_bytes = ADDR_W'(4);
    // words_loaded value seen during the WRITE of the final word
    localparam logic [ADDR_W-2:0] c_last_idx   = (ADDR_W-1)'(PROG_WORDS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_word;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-2:0]   r_words_loaded;
    logic                r_mem_wr_en;
    logic                r_cpu_run;
    logic                r_fetch_valid;

    logic                w_in_run;
    logic                w_byte_fire;

    assign w_in_run    = (r_state == ST_RUN);
    // byte_ready is high only in LOAD, so byte_valid alone qualifies a
    // handshake there; bytes offered in WRITE/RUN simply stall.
    assign w_byte_fire = (r_state == ST_LOAD) && byte_valid;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_LOAD;
            r_byte_cnt     <= 2'd0;
            r_word         <= 32'd0;
            r_wr_ptr       <= c_base_addr;
            r_words_loaded <= '0;
            r_mem_wr_en    <= 1'b0;
            r_cpu_run      <= 1'b0;
            r_fetch_valid  <= 1'b0;
        end else begin
            // fetch_valid is a one-cycle pulse per accepted request
            r_fetch_valid <= 1'b0;

            case (r_state)
                ST_LOAD: begin
                    if (w_byte_fire) begin
                        // little-endian packing: first byte lands in [7:0]
                        r_word[8*r_byte_cnt +: 8] <= byte_data;
                        r_byte_cnt                <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state     <= ST_WRITE;
                            r_mem_wr_en <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    // single write cycle; pointer and count advance on exit
                    r_mem_wr_en    <= 1'b0;
                    r_wr_ptr       <= r_wr_ptr + c_word_bytes;
                    r_words_loaded <= r_words_loaded + 1'b1;
                    if (r_words_loaded == c_last_idx) begin
                        r_state   <= ST_RUN;
                        r_cpu_run <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_RUN: begin
`ifdef IMEM_RELOAD_EN
                    if (reload) begin
                        // restart the load; a fetch accepted this cycle is
                        // dropped because fetch_valid stays at its default 0
                        r_state        <= ST_LOAD;
                        r_wr_ptr       <= c_base_addr;
                        r_byte_cnt     <= 2'd0;
                        r_words_loaded <= '0;
                        r_cpu_run      <= 1'b0;
                    end else begin
                        r_fetch_valid <= fetch_req;
                    end
`else
                    r_fetch_valid <= fetch_req;
`endif
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign byte_ready   = (r_state == ST_LOAD);

    // The CPU owns the address only in RUN; otherwise the write pointer is
    // presented, so a fetch request outside RUN never reaches the memory.
    assign mem_addr     = w_in_run ? fetch_addr : r_wr_ptr;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_wdata    = r_word;

    assign fetch_valid  = r_fetch_valid;
    assign fetch_data   = mem_rdata;

    assign cpu_run      = r_cpu_run;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_ctrl
// Purpose  : Self-checking bench for imem_boot_ctrl with a two-word program.
//            A behavioural memory sits on the memory port; expected writes
//            and fetch results are queued as stimulus is driven and compared
//            against what the DUT produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_ctrl;

    localparam int ADDR_W     = 14;
    localparam int PROG_WORDS = 2;
    localparam int BASE_ADDR  = 0;
    localparam int MEM_WORDS  = 1 << (ADDR_W - 2);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                byte_valid = 1'b0;
    logic [7:0]          byte_data = 8'h00;
    logic                byte_ready;
    logic                fetch_req = 1'b0;
    logic [ADDR_W-1:0]   fetch_addr = '0;
    logic                fetch_valid;
    logic [31:0]         fetch_data;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wr_en;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata = 32'd0;
    logic                cpu_run;
    logic [ADDR_W-2:0]   words_loaded;
`ifdef IMEM_RELOAD_EN
    logic                reload = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // scoreboard queues: {addr, data} for writes, data for fetches
    logic [ADDR_W+31:0]  exp_wr[$];
    logic [ADDR_W+31:0]  obs_wr[$];
    logic [31:0]         exp_f[$];
    logic [31:0]         obs_f[$];

    imem_boot_ctrl #(
        .ADDR_W     (ADDR_W),
        .PROG_WORDS (PROG_WORDS),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_run      (cpu_run),
`ifdef IMEM_RELOAD_EN
        .reload       (reload),
`endif
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // behavioural SPRAM: unwritten words read back as 0xA500_0000 | index
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        mem_filled = 1'b0;
    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem_filled <= 1'b1;
        end else begin
            if (mem_wr_en) mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[ADDR_W-1:2]];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- timing
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge, where observed writes/fetches are recorded.
    task automatic sample_cycle;
        @(negedge clk);
        if (rst_n && mem_wr_en)   obs_wr.push_back({mem_addr, mem_wdata});
        if (rst_n && fetch_valid) obs_f.push_back(fetch_data);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        byte_valid = 1'b0;
        fetch_req = 1'b0;
        sample_cycle(); next_cycle();
        sample_cycle(); next_cycle();
        rst_n = 1'b1;
        exp_wr.delete(); obs_wr.delete();
        exp_f.delete();  obs_f.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 0) begin
                byte_valid = 1'b0;
                sample_cycle(); next_cycle();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        sample_cycle();
        while (!byte_ready && guard < 20) begin
            next_cycle(); sample_cycle();
            guard++;
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL byte_handshake: byte_ready=%b after %0d cycles, required 1", byte_ready, guard);
        end
        next_cycle();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit gaps);
        exp_wr.push_back({a, d});
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gaps);
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_run !== 1'b0 || mem_wr_en !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: cpu_run=%b mem_wr_en=%b fetch_valid=%b, required 0 0 0",
                     cpu_run, mem_wr_en, fetch_valid);
        end
        apply_reset();
        sample_cycle();
        checks++;
        if (words_loaded !== '0 || byte_ready !== 1'b1 || mem_addr !== ADDR_W'(BASE_ADDR)
            || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: words_loaded=%0d byte_ready=%b mem_addr=%h mem_wdata=%h, required 0 1 %h 0",
                     words_loaded, byte_ready, mem_addr, mem_wdata, ADDR_W'(BASE_ADDR));
        end
        next_cycle();
    endtask

    task automatic test_load;
        logic [ADDR_W+31:0] e, o;
        apply_reset();
        send_word(ADDR_W'(0), 32'h1234_5678, 1'b0);
        sample_cycle();
        checks++;
        if (mem_wr_en !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_write_latency: mem_wr_en=%b byte_ready=%b, required 1 0", mem_wr_en, byte_ready);
        end
        next_cycle();
        sample_cycle();
        checks++;
        if (mem_addr !== ADDR_W'(4) || words_loaded !== (ADDR_W-1)'(1) || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL load_advance: mem_addr=%h words_loaded=%0d mem_wr_en=%b, required 0004 1 0",
                     mem_addr, words_loaded, mem_wr_en);
        end
        next_cycle();
        send_word(ADDR_W'(4), 32'hDEAD_BEEF, 1'b0);
        sample_cycle();
        checks++;
        if (cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL load_cpu_run_early: cpu_run=%b in last write cycle, required 0", cpu_run);
        end
        next_cycle();
        sample_cycle();
        checks++;
        if (cpu_run !== 1'b1 || words_loaded !== (ADDR_W-1)'(2)) begin
            errors++;
            $display("FAIL load_cpu_run: cpu_run=%b words_loaded=%0d, required 1 2", cpu_run, words_loaded);
        end
        next_cycle();
        // loader bytes stall in RUN
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            sample_cycle();
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_stall: byte_ready=%b in RUN, required 0", byte_ready);
            end
            next_cycle();
        end
        byte_valid = 1'b0;
        checks++;
        if (obs_wr.size() != exp_wr.size() || words_loaded !== (ADDR_W-1)'(2)) begin
            errors++;
            $display("FAIL load_wr_count: writes=%0d words_loaded=%0d, required %0d 2",
                     obs_wr.size(), words_loaded, exp_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_wr: addr=%h data=%h, required addr=%h data=%h",
                         o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
    endtask

    task automatic test_fetch;
        logic [31:0] e, o;
        logic [31:0] words [3];
        logic [4:0]  exp_v;
        words[0] = 32'h1234_5678;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'hA500_0002;
        exp_v    = 5'b01110;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                fetch_req  = 1'b1;
                fetch_addr = ADDR_W'(4 * c);
                exp_f.push_back(words[c]);
            end else begin
                fetch_req = 1'b0;
            end
            sample_cycle();
            checks++;
            if (fetch_valid !== exp_v[c] || mem_wr_en !== 1'b0 || mem_addr !== fetch_addr) begin
                errors++;
                $display("FAIL fetch_timing: cycle %0d fetch_valid=%b mem_wr_en=%b mem_addr=%h, required %b 0 %h",
                         c, fetch_valid, mem_wr_en, mem_addr, exp_v[c], fetch_addr);
            end
            next_cycle();
        end
        checks++;
        if (obs_f.size() != exp_f.size()) begin
            errors++;
            $display("FAIL fetch_count: valids=%0d, required %0d", obs_f.size(), exp_f.size());
        end
        while (exp_f.size() != 0 && obs_f.size() != 0) begin
            e = exp_f.pop_front();
            o = obs_f.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fetch_data: data=%h, required %h", o, e);
            end
        end
    endtask

    task automatic test_gaps;
        logic [ADDR_W+31:0] e, o;
        apply_reset();
        send_word(ADDR_W'(0), 32'h1234_5678, 1'b1);
        send_word(ADDR_W'(4), 32'hDEAD_BEEF, 1'b1);
        sample_cycle(); next_cycle();
        sample_cycle();
        checks++;
        if (cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL gaps_cpu_run: cpu_run=%b, required 1", cpu_run);
        end
        next_cycle();
        checks++;
        if (obs_wr.size() != 2) begin
            errors++;
            $display("FAIL gaps_wr_cycles: write cycles=%0d, required 2", obs_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gaps_wr: addr=%h data=%h, required addr=%h data=%h",
                         o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
    endtask

    task automatic test_fetch_in_load;
        logic [ADDR_W+31:0] e, o;
        apply_reset();
        fetch_req  = 1'b1;
        fetch_addr = ADDR_W'(8);
        for (int c = 0; c < 3; c++) begin
            sample_cycle();
            checks++;
            if (fetch_valid !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== ADDR_W'(BASE_ADDR)) begin
                errors++;
                $display("FAIL load_fetch_ignored: fetch_valid=%b mem_wr_en=%b mem_addr=%h, required 0 0 %h",
                         fetch_valid, mem_wr_en, mem_addr, ADDR_W'(BASE_ADDR));
            end
            next_cycle();
        end
        send_word(ADDR_W'(0), 32'hCAFE_F00D, 1'b0);
        sample_cycle(); next_cycle();
        fetch_req = 1'b0;
        checks++;
        if (obs_f.size() != 0 || obs_wr.size() != 1) begin
            errors++;
            $display("FAIL load_fetch_side_effect: valids=%0d writes=%0d, required 0 1", obs_f.size(), obs_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_fetch_wr: addr=%h data=%h, required addr=%h data=%h",
                         o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_midword;
        logic [ADDR_W+31:0] e, o;
        apply_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || words_loaded !== '0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL midword_reset: mem_wr_en=%b words_loaded=%0d byte_ready=%b, required 0 0 1",
                     mem_wr_en, words_loaded, byte_ready);
        end
        apply_reset();
        send_word(ADDR_W'(BASE_ADDR), 32'hDDCC_BBAA, 1'b0);
        sample_cycle(); next_cycle();
        sample_cycle();
        checks++;
        if (words_loaded !== (ADDR_W-1)'(1) || mem_addr !== ADDR_W'(BASE_ADDR + 4)) begin
            errors++;
            $display("FAIL midword_advance: words_loaded=%0d mem_addr=%h, required 1 %h",
                     words_loaded, mem_addr, ADDR_W'(BASE_ADDR + 4));
        end
        next_cycle();
        checks++;
        if (obs_wr.size() != 1) begin
            errors++;
            $display("FAIL midword_wr_count: writes=%0d, required 1", obs_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midword_wr: addr=%h data=%h, required addr=%h data=%h",
                         o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
    endtask

`ifdef IMEM_RELOAD_EN
    task automatic test_reload;
        logic [ADDR_W+31:0] e, o;
        apply_reset();
        send_word(ADDR_W'(0), 32'h0101_0101, 1'b0);
        send_word(ADDR_W'(4), 32'h0202_0202, 1'b0);
        sample_cycle(); next_cycle();
        sample_cycle(); next_cycle();
        exp_wr.delete(); obs_wr.delete();
        reload     = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = ADDR_W'(0);
        sample_cycle(); next_cycle();
        reload    = 1'b0;
        fetch_req = 1'b0;
        sample_cycle();
        checks++;
        if (fetch_valid !== 1'b0 || cpu_run !== 1'b0 || byte_ready !== 1'b1
            || words_loaded !== '0 || mem_addr !== ADDR_W'(BASE_ADDR)) begin
            errors++;
            $display("FAIL reload_state: fetch_valid=%b cpu_run=%b byte_ready=%b words_loaded=%0d mem_addr=%h, required 0 0 1 0 %h",
                     fetch_valid, cpu_run, byte_ready, words_loaded, mem_addr, ADDR_W'(BASE_ADDR));
        end
        next_cycle();
        send_word(ADDR_W'(BASE_ADDR), 32'h0BAD_C0DE, 1'b0);
        sample_cycle(); next_cycle();
        checks++;
        if (obs_f.size() != 0 || obs_wr.size() != 1) begin
            errors++;
            $display("FAIL reload_counts: valids=%0d writes=%0d, required 0 1", obs_f.size(), obs_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reload_wr: addr=%h data=%h, required addr=%h data=%h",
                         o[ADDR_W+31:32], o[31:0], e[ADDR_W+31:32], e[31:0]);
            end
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_load();
        test_fetch();
        test_gaps();
        test_fetch_in_load();
        test_reset_midword();
`ifdef IMEM_RELOAD_EN
        test_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
